// File: rtl/sa_out_packer.sv
// sa_out_packer: packs narrow array result lanes into words and buffers them in a
// first-word-fall-through FIFO for the write DMA, counting the words of each frame.
module sa_out_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int IN_WIDTH   = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          i_start,
    input  logic [IN_WIDTH-1:0]           s_data,
    input  logic                          s_valid,
    input  logic                          s_last,
    output logic                          s_ready,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [CNT_WIDTH-1:0]          o_word_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);
    localparam int LANES = DATA_WIDTH / IN_WIDTH;
    localparam int LW    = LANES > 1 ? $clog2(LANES) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, PACK, DRAIN} state_t;

    state_t                state;
    logic [LW-1:0]         idx;
    logic [DATA_WIDTH-1:0] pack;
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wptr;
    logic [AW:0]           rptr;
    logic                  full;
    logic                  empty;
    logic                  accept;
    logic                  push;
    logic                  pop;

    assign o_fifo_level = wptr - rptr;
    assign empty        = wptr == rptr;
    assign full         = o_fifo_level == (AW+1)'(FIFO_DEPTH);
    assign s_ready      = state == PACK && !full;
    assign accept       = s_valid && s_ready;
    assign push         = accept && (s_last || idx == LW'(LANES-1));
    assign m_valid      = !empty;
    assign pop          = m_valid && m_ready;
    // Gate the head so stale storage never shows while the FIFO is empty.
    assign m_data       = empty ? '0 : mem[rptr[AW-1:0]];
    assign o_busy       = state != IDLE;
    // Unfilled upper lanes stay zero because pack is cleared after every push.
    assign word         = pack | (DATA_WIDTH'(s_data) << (idx * IN_WIDTH));

    always_ff @(posedge ACLK)
        if (push) mem[wptr[AW-1:0]] <= word;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state      <= IDLE;
            idx        <= '0;
            pack       <= '0;
            wptr       <= '0;
            rptr       <= '0;
            o_done     <= 1'b0;
            o_word_cnt <= '0;
        end else begin
            o_done <= 1'b0;
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            case (state)
                IDLE: if (i_start) begin
                    state      <= PACK;
                    idx        <= '0;
                    pack       <= '0;
                    o_word_cnt <= '0;
                end
                PACK: if (accept) begin
                    idx  <= push ? '0 : idx + 1'b1;
                    pack <= push ? '0 : word;
                    if (push) o_word_cnt <= o_word_cnt + 1'b1;
                    if (s_last) state <= DRAIN;
                end
                default: if (o_fifo_level == (AW+1)'(pop)) begin
                    o_done <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sa_out_packer.sv
// tb_sa_out_packer: randomized frames checked against a lane-list packing model.
module tb_sa_out_packer;
    localparam int DW = 32, IW = 8, CW = 16;

    logic          ACLK = 0, ARESETN = 0, i_start = 0, s_valid = 0, s_last = 0, m_ready = 0;
    logic [IW-1:0] s_data = '0;
    logic          s_ready, m_valid, o_busy, o_done;
    logic [DW-1:0] m_data;
    logic [CW-1:0] o_word_cnt;
    logic [4:0]    o_fifo_level;

    int checks = 0, failures = 0, cyc = 0;
    int mr_mode = 1, v_pct = 100;
    int n_acc = 0, n_done = 0, word_acc_cyc = -1, first_mv_cyc = -1, last_pop_cyc = -1;
    logic          prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    logic [IW-1:0] lanes[$];
    logic [DW-1:0] got[$];

    sa_out_packer dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .i_start(i_start),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .o_busy(o_busy), .o_done(o_done), .o_word_cnt(o_word_cnt), .o_fifo_level(o_fifo_level)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    initial forever begin
        @(posedge ACLK);
        #1;
        m_ready = mr_mode == 2 ? ($urandom_range(0, 99) < 50) : (mr_mode == 1);
    end

    initial forever begin
        @(negedge ACLK);
        if (!ARESETN) prev_stall = 0;
        else begin
            if (prev_stall) check("m_data_hold", m_data, prev_data);
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (s_valid && s_ready) begin
                n_acc++;
                if (n_acc == 4) word_acc_cyc = cyc;
            end
            if (m_valid && first_mv_cyc < 0) first_mv_cyc = cyc;
            if (m_valid && m_ready) begin
                got.push_back(m_data);
                last_pop_cyc = cyc;
            end
            if (o_done) begin
                n_done++;
                check("done_timing", cyc, last_pop_cyc + 1);
            end
        end
    end

    task automatic new_frame(input int n, input int base);
        lanes.delete();
        got.delete();
        n_acc = 0;
        first_mv_cyc = -1;
        for (int i = 0; i < n; i++) lanes.push_back(base < 0 ? IW'($urandom) : IW'(base + i));
    endtask

    task automatic start();
        i_start = 1;
        @(posedge ACLK);
        #1;
        i_start = 0;
    endtask

    task automatic send(input int from, input int to, input bit last);
        int i = from;
        int t = 0;
        while (i < to && t < 20000) begin
            s_valid = $urandom_range(0, 99) < v_pct;
            s_data  = s_valid ? lanes[i] : IW'($urandom);
            s_last  = s_valid && last && i == to - 1;
            @(negedge ACLK);
            if (s_valid && s_ready) i++;
            @(posedge ACLK);
            #1;
            t++;
        end
        s_valid = 0;
        s_last  = 0;
        if (i < to) check("send_timeout", i, to);
    endtask

    task automatic wait_done(input int n0);
        int t = 0;
        while (n_done == n0 && t < 5000) begin
            @(posedge ACLK);
            #1;
            t++;
        end
        check("done_seen", n_done, n0 + 1);
        repeat (3) @(posedge ACLK);
        #1;
        check("done_once", n_done, n0 + 1);
        check("busy_idle", o_busy, 0);
    endtask

    task automatic check_words(input string tag);
        int nw = (lanes.size() + 3) / 4;
        logic [DW-1:0] e;
        check({tag, "_nwords"}, got.size(), nw);
        for (int j = 0; j < nw && j < got.size(); j++) begin
            e = '0;
            for (int k = 0; k < 4; k++)
                if (4 * j + k < lanes.size()) e[8*k +: 8] = lanes[4*j+k];
            check({tag, "_word"}, got[j], e);
        end
        check({tag, "_cnt"}, o_word_cnt, nw);
    endtask

    initial begin
        int n0, ng;
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_cnt", o_word_cnt, 0);
        check("rst_level", o_fifo_level, 0);
        ARESETN = 1;
        @(posedge ACLK);
        #1;

        new_frame(8, 1);
        n0 = n_done;
        start();
        check("t1_busy", o_busy, 1);
        send(0, 8, 1);
        wait_done(n0);
        check_words("t1");
        check("t1_latency", first_mv_cyc, word_acc_cyc + 1);

        new_frame(6, 'hA1);
        n0 = n_done;
        start();
        send(0, 6, 1);
        wait_done(n0);
        check_words("t2");
        check("t2_latency", first_mv_cyc, word_acc_cyc + 1);

        new_frame(72, -1);
        mr_mode = 0;
        n0 = n_done;
        start();
        fork
            send(0, 72, 1);
            begin
                for (int t = 0; t < 500 && n_acc < 64; t++) @(posedge ACLK);
                repeat (20) @(posedge ACLK);
                #1;
                check("t3_acc", n_acc, 64);
                check("t3_level", o_fifo_level, 16);
                check("t3_s_ready", s_ready, 0);
                mr_mode = 1;
            end
        join
        wait_done(n0);
        check_words("t3");

        new_frame(1000, -1);
        mr_mode = 2;
        v_pct = 60;
        n0 = n_done;
        start();
        send(0, 1000, 1);
        wait_done(n0);
        check_words("t4");
        v_pct = 100;

        new_frame(12, -1);
        mr_mode = 0;
        start();
        send(0, 12, 0);
        repeat (2) @(posedge ACLK);
        #1;
        check("t5_level_pre", o_fifo_level, 3);
        #1 ARESETN = 0;
        #1;
        check("t5_m_valid", m_valid, 0);
        check("t5_busy", o_busy, 0);
        check("t5_level", o_fifo_level, 0);
        check("t5_s_ready", s_ready, 0);
        @(negedge ACLK);
        @(posedge ACLK);
        #1 ARESETN = 1;
        check("t5_cnt_rst", o_word_cnt, 0);
        new_frame(4, -1);
        mr_mode = 1;
        n0 = n_done;
        start();
        send(0, 4, 1);
        wait_done(n0);
        check_words("t5");

        new_frame(8, -1);
        mr_mode = 0;
        n0 = n_done;
        start();
        send(0, 5, 0);
        start();
        repeat (2) @(posedge ACLK);
        #1;
        check("t6_busy", o_busy, 1);
        check("t6_level", o_fifo_level, 1);
        check("t6_cnt", o_word_cnt, 1);
        mr_mode = 1;
        send(5, 8, 1);
        wait_done(n0);
        check_words("t6");
        ng = got.size();
        s_valid = 1;
        s_last  = 1;
        for (int t = 0; t < 5; t++) begin
            s_data = IW'($urandom);
            @(posedge ACLK);
            #1;
            check("t6_idle_s_ready", s_ready, 0);
        end
        s_valid = 0;
        s_last  = 0;
        repeat (3) @(posedge ACLK);
        #1;
        check("t6_idle_words", got.size(), ng);
        check("t6_idle_level", o_fifo_level, 0);
        check("t6_idle_cnt", o_word_cnt, 2);
        check("t6_idle_busy", o_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
